gcm_tag_check: RTL and testbench

//  Receive-side GCM tag verifier: the checking end of the tag generator.

---
 rtl/gcm_pkg.sv | 14 +
 rtl/gf128_mul_digit.sv | 51 +++++
 rtl/gcm_tag_check.sv | 102 ++++++++++
 tb/tb_gcm_tag_check.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// gcm_pkg: shared GCM block type, reduction constant and tag-check FSM states
package gcm_pkg;
  typedef logic [0:127] gcm_blk_t;
  localparam gcm_blk_t GCM_R = {8'hE1, 120'h0};
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MULT,
    ST_LENB,
    ST_MULT2,
    ST_FINAL,
    ST_DONE
  } gcm_chk_state_e;
endpackage

// File: rtl/gf128_mul_digit.sv
// gf128_mul_digit: digit-serial GF(2^128) multiplier consuming DIGIT bits of x per cycle
module gf128_mul_digit
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     start,
  input  gcm_blk_t x,
  input  gcm_blk_t h,
  output logic     busy,
  output logic     done,
  output gcm_blk_t z
);
  localparam int STEPS = 128 / DIGIT;
  gcm_blk_t x_q, z_q, v_q, v_nxt;
  logic [7:0] cnt_q;
  // fold the next DIGIT bits of x into z; z is the finished product while done is high
  always_comb begin
    z = z_q;
    v_nxt = v_q;
    for (int i = 0; i < DIGIT; i++) begin
      z = x_q[i] ? z ^ v_nxt : z;
      v_nxt = (v_nxt >> 1) ^ (v_nxt[127] ? GCM_R : '0);
    end
  end
  assign done = busy && cnt_q == 8'(STEPS - 1);
  // load operands on start, then advance one digit per cycle until the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      z_q <= '0;
      v_q <= '0;
      cnt_q <= '0;
      busy <= 1'b0;
    end else if (start) begin
      x_q <= x;
      z_q <= '0;
      v_q <= h;
      cnt_q <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      x_q <= x_q << DIGIT;
      z_q <= z;
      v_q <= v_nxt;
      cnt_q <= cnt_q + 8'd1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/gcm_tag_check.sv
// gcm_tag_check: receive-side GCM tag verifier (GHASH, length block, E_K(J0), tag compare)
module gcm_tag_check
  import gcm_pkg::*;
#(
  parameter int DIGIT    = 8,
  parameter int TAG_BITS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  gcm_blk_t    i_h,
  input  gcm_blk_t    i_ek_j0,
  input  logic [63:0] i_len_aad,
  input  logic [63:0] i_len_ct,
  input  gcm_blk_t    i_tag_rx,
  input  logic        i_start,
  input  logic        i_blk_valid,
  input  gcm_blk_t    i_blk,
  input  logic        i_blk_last,
  output logic        o_blk_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass
);
  localparam gcm_blk_t TAG_MASK = ~({128{1'b1}} >> TAG_BITS);
  gcm_chk_state_e state_q, state_nxt;
  gcm_blk_t y_q, h_q, ek_q, tag_q, mul_x, mul_z;
  logic [63:0] len_aad_q, len_ct_q;
  logic last_q, mul_start, mul_busy, mul_done, mul_step, take_start;
  assign mul_step = mul_busy && mul_done;
  assign take_start = (state_q == ST_IDLE || state_q == ST_DONE) && i_start;
  assign o_blk_ready = state_q == ST_LOAD;
  gf128_mul_digit #(.DIGIT(DIGIT)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(mul_start),
    .x(mul_x),
    .h(h_q),
    .busy(mul_busy),
    .done(mul_done),
    .z(mul_z)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_nxt;
  end
  // next state and multiplier launch: data blocks fold into Y, then the length block
  always_comb begin
    state_nxt = state_q;
    mul_start = 1'b0;
    mul_x = y_q ^ i_blk;
    case (state_q)
      ST_IDLE, ST_DONE: state_nxt = i_start ? ST_LOAD : state_q;
      ST_LOAD: begin
        mul_start = i_blk_valid;
        state_nxt = i_blk_valid ? ST_MULT : ST_LOAD;
      end
      ST_MULT: state_nxt = mul_step ? (last_q ? ST_LENB : ST_LOAD) : ST_MULT;
      ST_LENB: begin
        mul_start = 1'b1;
        mul_x = y_q ^ {len_aad_q, len_ct_q};
        state_nxt = ST_MULT2;
      end
      ST_MULT2: state_nxt = mul_step ? ST_FINAL : ST_MULT2;
      ST_FINAL: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end
  // sideband latches, GHASH accumulator and masked constant-time verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      h_q <= '0;
      ek_q <= '0;
      tag_q <= '0;
      len_aad_q <= '0;
      len_ct_q <= '0;
      last_q <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_pass <= 1'b0;
    end else begin
      o_done <= state_q == ST_FINAL;
      if (take_start) begin
        h_q <= i_h;
        ek_q <= i_ek_j0;
        tag_q <= i_tag_rx;
        len_aad_q <= i_len_aad;
        len_ct_q <= i_len_ct;
        y_q <= '0;
        o_pass <= 1'b0;
        o_busy <= 1'b1;
      end
      if (state_q == ST_LOAD && i_blk_valid) last_q <= i_blk_last;
      if ((state_q == ST_MULT || state_q == ST_MULT2) && mul_step) y_q <= mul_z;
      if (state_q == ST_FINAL) begin
        o_pass <= ((y_q ^ ek_q ^ tag_q) & TAG_MASK) == '0;
        o_busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gcm_tag_check.sv
// tb_gcm_tag_check: vector table, random messages against a GHASH model, abort and DIGIT sweep
module tb_gcm_tag_check;
  localparam logic [127:0] H    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EK   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C2   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] TAG2 = 128'hab6e47d42cec13bdf53a67b21257bddf;

  typedef struct {
    logic [63:0]  la;
    logic [63:0]  lc;
    logic [127:0] blk;
    logic [127:0] tag;
    logic         p128;
    logic         p96;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, vld, last;
  logic [127:0] h, ek, tag_rx, blk;
  logic [63:0] la, lc;
  logic [3:0] en, ready, busy, done, pass;
  int checks = 0;
  int failures = 0;
  logic [127:0] mq[$];
  vec_t tv[6];

  // instances 0/1 share timing (DIGIT 8, tags 128/96); 2/3 are DIGIT 1 and 32
  for (genvar g = 0; g < 4; g++) begin : g_dut
    gcm_tag_check #(
      .DIGIT(g == 2 ? 1 : g == 3 ? 32 : 8),
      .TAG_BITS(g == 1 ? 96 : 128)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_h(h),
      .i_ek_j0(ek),
      .i_len_aad(la),
      .i_len_ct(lc),
      .i_tag_rx(tag_rx),
      .i_start(start & en[g]),
      .i_blk_valid(vld & en[g]),
      .i_blk(blk),
      .i_blk_last(last),
      .o_blk_ready(ready[g]),
      .o_busy(busy[g]),
      .o_done(done[g]),
      .o_pass(pass[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // GCM multiply straight from the textbook bit-serial definition
  function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127 - i]) z ^= v;
      v = v[0] ? (v >> 1) ^ {8'he1, 120'h0} : v >> 1;
    end
    return z;
  endfunction

  function automatic logic [127:0] ref_tag();
    logic [127:0] y;
    y = '0;
    foreach (mq[i]) y = gmul(y ^ mq[i], h);
    return gmul(y ^ {la, lc}, h) ^ ek;
  endfunction

  // one message through instances 0 and 1; verdict, latency and pulse shape checked
  task automatic run_msg(input string name, input logic e128, input logic e96, input bit toggle);
    int cyc;
    bit acc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " ready_after_start"}, {busy[0], ready[0]}, 2'b11);
    foreach (mq[i]) begin
      blk = mq[i];
      last = (i == mq.size() - 1);
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 200) begin
        vld = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        start = toggle && $urandom_range(0, 3) == 0;
        acc = vld && ready[0];
        @(posedge clk); #1;
        start = 1'b0;
        vld = 1'b0;
        cyc++;
      end
      chk({name, " accept"}, acc, 1);
    end
    cyc = 1;
    while (!done[0] && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " latency"}, cyc, 2 * 16 + 3);
    chk({name, " done96"}, done[1], 1);
    chk({name, " pass128"}, pass[0], e128);
    chk({name, " pass96"}, pass[1], e96);
    @(posedge clk); #1;
    chk({name, " done_pulse"}, done[0], 0);
    chk({name, " busy_clear"}, busy[0], 0);
    chk({name, " pass_hold"}, pass[0], e128);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int l1, l32, cyc;
    bit seen;
    logic [127:0] t, d;
    tv[0] = '{64'd0, 64'd0, 128'd0, EK, 1'b1, 1'b1};
    tv[1] = '{64'd0, 64'd128, C2, TAG2, 1'b1, 1'b1};
    tv[2] = '{64'd0, 64'd128, C2, TAG2 ^ 128'h1, 1'b0, 1'b1};
    tv[3] = '{64'd0, 64'd128, C2, TAG2 ^ 128'hdeadbeef, 1'b0, 1'b1};
    tv[4] = '{64'd0, 64'd128, C2, TAG2 ^ {1'b1, 127'h0}, 1'b0, 1'b0};
    tv[5] = '{64'd0, 64'd0, 128'd0, EK ^ 128'h1_0000_0000, 1'b0, 1'b0};
    rst_n = 1'b0;
    start = 1'b0;
    vld = 1'b0;
    last = 1'b0;
    blk = '0;
    en = 4'b0011;
    h = H;
    ek = EK;
    la = '0;
    lc = '0;
    tag_rx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {ready, busy, done, pass}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (tv[i]) begin
      la = tv[i].la;
      lc = tv[i].lc;
      tag_rx = tv[i].tag;
      mq.delete();
      mq.push_back(tv[i].blk);
      run_msg($sformatf("vec%0d", i), tv[i].p128, tv[i].p96, i % 2 == 1);
    end
    for (int n = 0; n < 16; n++) begin
      h = {$urandom, $urandom, $urandom, $urandom};
      ek = {$urandom, $urandom, $urandom, $urandom};
      la = {$urandom, $urandom};
      lc = {$urandom, $urandom};
      mq.delete();
      for (int b = 0; b < $urandom_range(1, 4); b++) mq.push_back({$urandom, $urandom, $urandom, $urandom});
      t = ref_tag();
      d = $urandom_range(0, 1) ? '0 : (n % 4 == 0 ? 128'h1 << $urandom_range(0, 127) : {$urandom, $urandom, $urandom, $urandom} | 128'h1);
      tag_rx = t ^ d;
      run_msg($sformatf("rand%0d", n), d == '0, d[127:32] == '0, 1'b1);
    end
    h = H;
    ek = EK;
    la = '0;
    lc = 64'd128;
    tag_rx = TAG2;
    blk = C2;
    last = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", busy[1:0], 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {ready[1:0], busy[1:0], done[1:0], pass[1:0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      seen |= done[0] | done[1];
    end
    chk("abort_no_done", seen, 0);
    la = '0;
    lc = '0;
    tag_rx = EK;
    mq.delete();
    mq.push_back('0);
    run_msg("after_abort", 1'b1, 1'b1, 1'b0);
    en = 4'b1100;
    la = '0;
    lc = 64'd128;
    tag_rx = TAG2;
    blk = C2;
    last = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("sweep_ready", ready[3:2], 2'b11);
    vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    l1 = 0;
    l32 = 0;
    cyc = 1;
    while ((l1 == 0 || l32 == 0) && cyc < 400) begin
      if (done[2] && l1 == 0) l1 = cyc;
      if (done[3] && l32 == 0) begin
        l32 = cyc;
        chk("sweep_pass_d32", pass[3], 1);
        start = 1'b1;
      end
      @(posedge clk); #1;
      if (start) begin
        start = 1'b0;
        chk("start_on_done_load", {busy[3], ready[3], pass[3]}, 3'b110);
        chk("start_ignored_busy_d1", ready[2], 0);
      end
      cyc++;
    end
    chk("sweep_latency_d1", l1, 2 * 128 + 3);
    chk("sweep_latency_d32", l32, 2 * 4 + 3);
    chk("sweep_pass_d1", pass[2], 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
